centroid_div_sched: RTL
=======================

Name: centroid_div_sched

Overview:
- Sequencing controller for the object-position datapath.
- At each end-of-frame it snapshots the accumulated pixel count and the x/y coordinate sums.
- It time-shares one serial restoring divider: first x, then y. It publishes the centroid with a one-cycle valid pulse.
- Sits between the coordinate accumulators and the tracking/overlay logic. It replaces a single-cycle wide divide with a bounded multi-cycle schedule.

Parameters:
- INPUT_WIDTH, 11, width of the x_position/y_position results (VGA coordinate width).
- COUNT_WIDTH, 19, width of the pixel-count divisor.
- SUM_WIDTH, 27, width of the coordinate-sum dividends; also the number of divide iterations per axis.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- aresetn  input  1  synchronous, active-low reset.
- enable  input  1  block enable; low = synchronous abort/clear.
- frame_done  input  1  one-cycle pulse marking the end of frame; sums are valid in the same cycle.
- total_count  input  COUNT_WIDTH  matched-pixel count for the frame.
- x_sum  input  SUM_WIDTH  sum of x coordinates of matched pixels.
- y_sum  input  SUM_WIDTH  sum of y coordinates of matched pixels.
- x_position  output  INPUT_WIDTH  registered centroid x.
- y_position  output  INPUT_WIDTH  registered centroid y.
- position_valid  output  1  one-cycle pulse when the position outputs update.
- no_object  output  1  registered with each valid pulse; 1 = frame had zero matched pixels.
- busy  output  1  high in any state other than IDLE.
- frame_overrun  output  1  one-cycle pulse when frame_done arrives while busy.

Behaviour:
- Reset and enable:
  - Reset (aresetn=0 at the clock edge) forces state IDLE and drives all outputs to 0.
  - Reset takes priority over enable.
  - enable=0 has the same effect as reset. Any in-flight divide is abandoned and no valid pulse is produced.
- State machine, states IDLE, DIV_X, DIV_Y, DONE:
  - IDLE with frame_done=1 and total_count!=0: snapshot total_count, x_sum, y_sum into internal registers, then go to DIV_X with iteration counter = SUM_WIDTH-1.
  - IDLE with frame_done=1 and total_count==0: go to DONE with a zero-count flag set; no divide runs.
  - DIV_X: one restoring iteration per cycle, MSB first.
    - Remainder is COUNT_WIDTH+1 bits: rem = {rem, dividend bit}; if rem >= divisor then subtract and quotient bit = 1.
    - After SUM_WIDTH iterations, latch the x quotient, reload for y, go to DIV_Y.
  - DIV_Y: identical, SUM_WIDTH iterations, then go to DONE.
  - DONE, one cycle: update outputs, assert position_valid, go to IDLE.
- Latency:
  - Edge E0 samples frame_done; position_valid is high in the cycle after edge E0+2*SUM_WIDTH+1 (E55 for defaults).
  - Zero-count path: valid after E1.
  - Throughput is one frame per 2*SUM_WIDTH+2 cycles.
- Result update in DONE:
  - Normal path: x_position/y_position = truncated quotient; no_object=0.
  - If a quotient exceeds 2^INPUT_WIDTH-1, the output saturates to all ones.
  - Zero-count path: x_position/y_position hold their previous values; no_object=1.
  - Between valid pulses the position outputs and no_object hold.
- frame_done while not in IDLE (DIV_X, DIV_Y or DONE): ignored for data; frame_overrun pulses the next cycle; the current computation is unaffected.
- Back-to-back: frame_done in the same cycle the FSM is in IDLE after DONE is accepted normally.
- The snapshot isolates the divide from input changes after E0; inputs are don't-care outside the frame_done cycle.
- busy=0 only in IDLE.

Test Plan:
- Reset: aresetn=0 for 2 cycles with frame_done pulsing -> all outputs 0, busy=0, no valid pulse.
- Nominal: total_count=4, x_sum=1280, y_sum=960, frame_done at E0 -> valid pulse exactly at E55 with x=320, y=240, no_object=0; busy high E0..E55.
- Truncation: total_count=3, x_sum=10, y_sum=5 -> x=3, y=1.
- Zero count, after the nominal case: total_count=0, frame_done -> valid at E1, no_object=1, x/y remain 320/240, no divide cycles (busy high for 1 cycle).
- Overrun: frame_done at E0 (count=4, x_sum=1280, y_sum=960), second frame_done at E20 with different sums -> frame_overrun pulse at E21; result at E55 is still 320/240.
- Abort and saturation:
  - enable=0 at E30 mid-divide -> state IDLE, outputs 0, no valid at E55.
  - Then count=1, x_sum=5000, y_sum=7 -> x=2047 (saturated), y=7.

Source files
------------

// File: rtl/centroid_div_sched_if.sv
// ---------------------------------------------------------------------------
// centroid_div_sched_if
// Signal bundle between the coordinate accumulators / tracking logic and the
// centroid divide scheduler.
//   master : drives enable, frame_done, total_count, x_sum, y_sum and
//            receives the centroid results and status flags.
//   slave  : the scheduler itself (centroid_div_sched).
// Ports of the bundle:
//   enable          block enable, low = synchronous abort/clear
//   frame_done      one-cycle end-of-frame pulse, sums valid in that cycle
//   total_count     matched-pixel count (divisor)
//   x_sum / y_sum   coordinate sums (dividends)
//   x_position      registered centroid x
//   y_position      registered centroid y
//   position_valid  one-cycle pulse when positions update
//   no_object       1 = last published frame had zero matched pixels
//   busy            high whenever the scheduler is not idle
//   frame_overrun   one-cycle pulse when frame_done arrives while busy
// ---------------------------------------------------------------------------
interface centroid_div_sched_if #(
  parameter int INPUT_WIDTH = 11,
  parameter int COUNT_WIDTH = 19,
  parameter int SUM_WIDTH   = 27
);
  logic                   enable;
  logic                   frame_done;
  logic [COUNT_WIDTH-1:0] total_count;
  logic [SUM_WIDTH-1:0]   x_sum;
  logic [SUM_WIDTH-1:0]   y_sum;
  logic [INPUT_WIDTH-1:0] x_position;
  logic [INPUT_WIDTH-1:0] y_position;
  logic                   position_valid;
  logic                   no_object;
  logic                   busy;
  logic                   frame_overrun;

  modport master (
    output enable, frame_done, total_count, x_sum, y_sum,
    input  x_position, y_position, position_valid, no_object, busy,
           frame_overrun
  );

  modport slave (
    input  enable, frame_done, total_count, x_sum, y_sum,
    output x_position, y_position, position_valid, no_object, busy,
           frame_overrun
  );
endinterface

// File: rtl/centroid_div_sched.sv
// ---------------------------------------------------------------------------
// centroid_div_sched
// Computes the object centroid at every end of frame by time-sharing one
// serial restoring divider: x_sum / total_count first, then
// y_sum / total_count, one quotient bit per clock, MSB first.
// Ports:
//   clk      system clock, rising edge
//   aresetn  synchronous active-low reset (takes priority over enable)
//   bus      centroid_div_sched_if.slave (inputs, results, status)
// Latency: frame_done sampled at edge E0 -> position_valid high after edge
// E0 + 2*SUM_WIDTH + 1. A zero pixel count skips the divide and reports
// no_object one edge later while holding the previous position.
// ---------------------------------------------------------------------------
module centroid_div_sched #(
  parameter int INPUT_WIDTH = 11,
  parameter int COUNT_WIDTH = 19,
  parameter int SUM_WIDTH   = 27
) (
  input logic                 clk,
  input logic                 aresetn,
  centroid_div_sched_if.slave bus
);

  localparam int ITER_WIDTH = $clog2(SUM_WIDTH);
  localparam logic [ITER_WIDTH-1:0] LAST_ITER = ITER_WIDTH'(SUM_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    DONE
  } state_t;

  state_t                 state;
  logic [ITER_WIDTH-1:0]  iter;
  logic [COUNT_WIDTH-1:0] divisor;
  logic [SUM_WIDTH-1:0]   dividend;   // shifts left, MSB feeds the remainder
  logic [SUM_WIDTH-1:0]   y_hold;     // y_sum snapshot waiting for its turn
  logic [SUM_WIDTH-1:0]   quotient;
  logic [COUNT_WIDTH:0]   rem;        // one extra bit so the shift never overflows
  logic [INPUT_WIDTH-1:0] x_res;
  logic [INPUT_WIDTH-1:0] y_res;
  logic                   zero_count;

  // One restoring-division step, shared by both axes.
  logic [COUNT_WIDTH:0]   rem_shift;
  logic [COUNT_WIDTH:0]   rem_next;
  logic                   q_bit;
  logic [SUM_WIDTH-1:0]   quo_next;

  // NOTE: every signal driven here is assigned on every path through the
  // block, so no latch can be inferred.
  always_comb begin
    rem_shift = {rem[COUNT_WIDTH-1:0], dividend[SUM_WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, divisor});
    rem_next  = q_bit ? (rem_shift - {1'b0, divisor}) : rem_shift;
    quo_next  = {quotient[SUM_WIDTH-2:0], q_bit};
  end

  // Clamp a full-width quotient into the output coordinate range.
  function automatic logic [INPUT_WIDTH-1:0] saturate(
    input logic [SUM_WIDTH-1:0] q
  );
    if (|q[SUM_WIDTH-1:INPUT_WIDTH]) return '1;
    else                             return q[INPUT_WIDTH-1:0];
  endfunction

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!aresetn || !bus.enable) begin
      // Disable behaves exactly like reset: the in-flight divide is dropped.
      state              <= IDLE;
      iter               <= '0;
      divisor            <= '0;
      dividend           <= '0;
      y_hold             <= '0;
      quotient           <= '0;
      rem                <= '0;
      x_res              <= '0;
      y_res              <= '0;
      zero_count         <= 1'b0;
      bus.x_position     <= '0;
      bus.y_position     <= '0;
      bus.position_valid <= 1'b0;
      bus.no_object      <= 1'b0;
      bus.busy           <= 1'b0;
      bus.frame_overrun  <= 1'b0;
    end else begin
      bus.position_valid <= 1'b0;
      // A frame end outside IDLE is dropped; only flag it.
      bus.frame_overrun  <= bus.frame_done && (state != IDLE);

      case (state)
        IDLE: begin
          if (bus.frame_done) begin
            bus.busy <= 1'b1;
            if (bus.total_count != '0) begin
              divisor    <= bus.total_count;
              dividend   <= bus.x_sum;
              y_hold     <= bus.y_sum;
              quotient   <= '0;
              rem        <= '0;
              iter       <= LAST_ITER;
              zero_count <= 1'b0;
              state      <= DIV_X;
            end else begin
              zero_count <= 1'b1;
              state      <= DONE;
            end
          end
        end

        DIV_X: begin
          rem      <= rem_next;
          quotient <= quo_next;
          dividend <= {dividend[SUM_WIDTH-2:0], 1'b0};
          iter     <= iter - ITER_WIDTH'(1);
          if (iter == '0) begin
            // Last x bit resolved: park the result and restart on y.
            x_res    <= saturate(quo_next);
            dividend <= y_hold;
            quotient <= '0;
            rem      <= '0;
            iter     <= LAST_ITER;
            state    <= DIV_Y;
          end
        end

        DIV_Y: begin
          rem      <= rem_next;
          quotient <= quo_next;
          dividend <= {dividend[SUM_WIDTH-2:0], 1'b0};
          iter     <= iter - ITER_WIDTH'(1);
          if (iter == '0) begin
            y_res <= saturate(quo_next);
            state <= DONE;
          end
        end

        DONE: begin
          bus.position_valid <= 1'b1;
          bus.no_object      <= zero_count;
          // An empty frame keeps the last known position.
          if (!zero_count) begin
            bus.x_position <= x_res;
            bus.y_position <= y_res;
          end
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
